pll_rst_seq: RTL



---
 rtl/pll_rst_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// Lock-qualified reset sequencer in the PLL reference-clock domain.
// Pulses the PLL reset, waits for a debounced lock (timeout + bounded
// retry), then releases N_CH channel resets one after another. It
// re-sequences on lock loss and parks the PLL in standby on sleep_req.
module pll_rst_seq #(
  parameter int RST_HOLD_CYC     = 24,
  parameter int LOCK_STABLE_CYC  = 240,
  parameter int LOCK_TIMEOUT_CYC = 24000,
  parameter int MAX_RETRY        = 3,
  parameter int N_CH             = 3,
  parameter int STAGGER_CYC      = 16
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic                           pll_extlock,
  input  logic                           sleep_req,
  output logic                           pll_reset,
  output logic                           pll_stdby,
  output logic [N_CH-1:0]                ch_rst_n,
  output logic                           ready,
  output logic                           fault,
  output logic                           lock_lost,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int HOLD_W   = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
  localparam int TO_W     = $clog2(LOCK_TIMEOUT_CYC);
  localparam int STAB_W   = $clog2(LOCK_STABLE_CYC + 1);
  localparam int STAG_MAX = (N_CH - 1) * STAGGER_CYC;
  localparam int STAG_W   = (STAG_MAX > 0) ? $clog2(STAG_MAX + 1) : 1;
  localparam int RTY_W    = $clog2(MAX_RETRY + 1);

  localparam logic [2:0] S_RST_PLL   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_SLEEP     = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic [1:0]        lock_sync_q;
  logic              lock_s;
  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [STAG_W-1:0] stag_q, stag_d;
  logic [RTY_W-1:0]  retry_q, retry_d, retry_inc;
  logic              pll_reset_q, pll_reset_d;
  logic              pll_stdby_q, pll_stdby_d;
  logic [N_CH-1:0]   ch_q, ch_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;
  logic              lost_q, lost_d;

  assign lock_s    = lock_sync_q[1];
  assign retry_inc = retry_q + RTY_W'(1);

  // Next-state and registered-output computation; outputs follow the
  // state being entered so every output is a flop.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    to_d        = to_q;
    stab_d      = stab_q;
    stag_d      = stag_q;
    retry_d     = retry_q;
    pll_reset_d = pll_reset_q;
    pll_stdby_d = pll_stdby_q;
    ch_d        = ch_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    lost_d      = lost_q;
    case (state_q)
      S_RST_PLL: begin
        pll_reset_d = 1'b1;
        ch_d        = '0;
        ready_d     = 1'b0;
        if (hold_q == HOLD_W'(RST_HOLD_CYC - 1)) begin
          state_d     = S_WAIT_LOCK;
          pll_reset_d = 1'b0;
          to_d        = '0;
          stab_d      = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        pll_reset_d = 1'b0;
        stab_d      = lock_s ? stab_q + STAB_W'(1) : '0;
        to_d        = to_q + TO_W'(1);
        // Stable completion is checked first so it wins over a same-cycle timeout.
        if (lock_s && stab_q == STAB_W'(LOCK_STABLE_CYC - 1)) begin
          state_d = S_RELEASE;
          stag_d  = '0;
        end else if (to_q == TO_W'(LOCK_TIMEOUT_CYC - 1)) begin
          retry_d = retry_inc;
          if (retry_inc == RTY_W'(MAX_RETRY)) begin
            state_d     = S_FAULT;
            fault_d     = 1'b1;
            pll_stdby_d = 1'b1;
          end else begin
            state_d     = S_RST_PLL;
            pll_reset_d = 1'b1;
            hold_d      = '0;
          end
        end
      end
      S_RELEASE: begin
        if (!lock_s) begin
          state_d     = S_RST_PLL;
          pll_reset_d = 1'b1;
          ch_d        = '0;
          hold_d      = '0;
        end else begin
          for (int i = 0; i < N_CH; i++)
            ch_d[i] = (int'(stag_q) >= i * STAGGER_CYC);
          if (stag_q == STAG_W'(STAG_MAX)) begin
            state_d = S_RUN;
            ready_d = 1'b1;
            retry_d = '0;
          end else begin
            stag_d = stag_q + STAG_W'(1);
          end
        end
      end
      S_RUN: begin
        // Lock loss has priority over a coincident sleep request.
        if (!lock_s) begin
          state_d     = S_RST_PLL;
          pll_reset_d = 1'b1;
          ch_d        = '0;
          ready_d     = 1'b0;
          lost_d      = 1'b1;
          hold_d      = '0;
        end else if (sleep_req) begin
          state_d = S_SLEEP;
          ch_d    = '0;
          ready_d = 1'b0;
        end
      end
      S_SLEEP: begin
        // Lock is meaningless while the PLL is in standby.
        if (!sleep_req) begin
          state_d     = S_RST_PLL;
          pll_stdby_d = 1'b0;
          pll_reset_d = 1'b1;
          hold_d      = '0;
        end else begin
          pll_stdby_d = 1'b1;
        end
      end
      S_FAULT: begin
        fault_d     = 1'b1;
        pll_stdby_d = 1'b1;
        pll_reset_d = 1'b0;
        ch_d        = '0;
        ready_d     = 1'b0;
      end
      default: begin
        state_d     = S_RST_PLL;
        pll_reset_d = 1'b1;
        ch_d        = '0;
        ready_d     = 1'b0;
        hold_d      = '0;
      end
    endcase
  end

  // Two-flop lock synchroniser plus all sequencer state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      state_q     <= S_RST_PLL;
      hold_q      <= '0;
      to_q        <= '0;
      stab_q      <= '0;
      stag_q      <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      pll_stdby_q <= 1'b0;
      ch_q        <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_extlock};
      state_q     <= state_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      stab_q      <= stab_d;
      stag_q      <= stag_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      pll_stdby_q <= pll_stdby_d;
      ch_q        <= ch_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lost_q      <= lost_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign pll_stdby = pll_stdby_q;
  assign ch_rst_n  = ch_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;

endmodule
